// File: rtl/parking_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_pkg: shared exit-FSM states, default sizing, fee width rule  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } exit_state_t;

  localparam int c_DEF_NUM_SLOTS = 4;
  localparam int c_DEF_TIME_W    = 4;
  localparam int c_DEF_RATE_W    = 4;
  localparam int c_DEF_RATE      = 2;

  // Product of a TIME_W duration and a RATE_W rate never needs more bits.
  function automatic int fee_width(input int time_w, input int rate_w);
    return time_w + rate_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fee_serial_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fee_serial_mult: LSB-first shift-add multiply of RATE by a duration  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fee_serial_mult
  import parking_pkg::*;
#(
  parameter int TIME_W = c_DEF_TIME_W,
  parameter int RATE_W = c_DEF_RATE_W,
  parameter int RATE   = c_DEF_RATE,
  localparam int FEE_W = fee_width(TIME_W, RATE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [TIME_W-1:0] i_multiplier,
  output logic              o_busy,
  output logic              o_done,
  output logic [FEE_W-1:0]  o_product
);

  localparam int c_CNT_W = $clog2(TIME_W + 1);
  localparam logic [FEE_W-1:0] c_MCAND = FEE_W'(RATE);

  logic              r_busy;
  logic [c_CNT_W-1:0] r_cnt;
  logic [FEE_W-1:0]  r_acc;
  logic [FEE_W-1:0]  r_mcand;
  logic [TIME_W-1:0] r_mplier;
  logic [FEE_W-1:0]  r_product;
  logic [FEE_W-1:0]  w_acc_next;
  logic              w_last;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = r_busy && (r_cnt == c_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= c_CNT_W'(TIME_W);
      r_acc    <= '0;
      r_mcand  <= c_MCAND;
      r_mplier <= i_multiplier;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - c_CNT_W'(1);
      // The product register only moves on completion so it holds between bills.
      if (w_last) begin
        r_busy    <= 1'b0;
        r_product <= w_acc_next;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_product = r_product;

endmodule
`default_nettype wire

// File: rtl/parking_lot_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_lot_ctrl: lowest-free bay allocation, entry stamping and     |
// | serial exit billing. PARKING_REVENUE_EN adds a revenue accumulator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = c_DEF_NUM_SLOTS,
  parameter int TIME_W    = c_DEF_TIME_W,
  parameter int RATE_W    = c_DEF_RATE_W,
  parameter int RATE      = c_DEF_RATE,
  localparam int FEE_W    = fee_width(TIME_W, RATE_W),
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 entry_req,
  output logic                 entry_ack,
  output logic                 entry_nack,
  output logic [NUM_SLOTS-1:0] entry_slot,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 exit_ready,
  output logic                 exit_err,
  output logic                 fee_valid,
  output logic [FEE_W-1:0]     fee,
  output logic [SLOT_W-1:0]    fee_slot,
  output logic [NUM_SLOTS-1:0] free_mask,
  output logic                 full,
  output logic [TIME_W-1:0]    now
`ifdef PARKING_REVENUE_EN
  ,
  output logic [FEE_W+7:0]     revenue
`endif
);

  exit_state_t          r_state, w_state_next;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [TIME_W-1:0]    r_stamp [NUM_SLOTS];
  logic [TIME_W-1:0]    r_now;
  logic [SLOT_W-1:0]    r_slot;
  logic [SLOT_W-1:0]    r_fee_slot;
  logic [TIME_W-1:0]    r_cap_now;
  logic                 r_entry_ack;
  logic                 r_entry_nack;
  logic [NUM_SLOTS-1:0] r_entry_slot;
  logic                 r_exit_err;

  logic                 w_any_free;
  logic                 w_grant;
  logic [SLOT_W-1:0]    w_grant_idx;
  logic [NUM_SLOTS-1:0] w_grant_1h;
  logic                 w_exit_valid;
  logic                 w_accept;
  logic [TIME_W-1:0]    w_dur_raw;
  logic [TIME_W-1:0]    w_duration;
  logic [NUM_SLOTS-1:0] w_release;
  logic                 w_exit_ready;
  logic                 w_fee_valid;
  logic                 w_mult_start;
  logic                 w_mult_busy;
  logic                 w_mult_done;
  logic [FEE_W-1:0]     w_product;

  always_comb begin
    w_grant_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_occ[i]) w_grant_idx = SLOT_W'(i);
    end
  end

  assign w_any_free   = ~&r_occ;
  assign w_grant      = entry_req && w_any_free;
  assign w_grant_1h   = NUM_SLOTS'(1) << w_grant_idx;
  assign w_exit_valid = (int'(exit_slot) < NUM_SLOTS) && r_occ[exit_slot];
  assign w_accept     = (r_state == IDLE) && exit_req && w_exit_valid;

  // Wrapping subtract is intended; a same-unit stay is billed one unit.
  assign w_dur_raw  = r_cap_now - r_stamp[r_slot];
  assign w_duration = (w_dur_raw == '0) ? TIME_W'(1) : w_dur_raw;
  assign w_release  = (r_state == DONE) ? (NUM_SLOTS'(1) << r_slot) : '0;

  always_comb begin
    w_state_next = r_state;
    w_exit_ready = 1'b0;
    w_fee_valid  = 1'b0;
    w_mult_start = 1'b0;
    case (r_state)
      IDLE: begin
        w_exit_ready = !w_mult_busy;
        if (w_accept) w_state_next = LOAD;
      end
      LOAD: begin
        w_mult_start = 1'b1;
        w_state_next = MULT;
      end
      MULT: if (w_mult_done) w_state_next = DONE;
      DONE: begin
        w_fee_valid  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_occ        <= '0;
      r_now        <= '0;
      r_slot       <= '0;
      r_fee_slot   <= '0;
      r_cap_now    <= '0;
      r_entry_ack  <= 1'b0;
      r_entry_nack <= 1'b0;
      r_entry_slot <= '0;
      r_exit_err   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_stamp[i] <= '0;
    end else begin
      r_state      <= w_state_next;
      if (tick) r_now <= r_now + TIME_W'(1);
      r_entry_ack  <= w_grant;
      r_entry_nack <= entry_req && !w_any_free;
      r_entry_slot <= w_grant ? w_grant_1h : '0;
      r_exit_err   <= (r_state == IDLE) && exit_req && !w_exit_valid;
      // A bay released in DONE is not offered to an entry in that same cycle.
      r_occ        <= (r_occ & ~w_release) | (w_grant ? w_grant_1h : '0);
      if (w_grant) r_stamp[w_grant_idx] <= r_now;
      if (w_accept) begin
        r_slot    <= exit_slot;
        r_cap_now <= r_now;
      end
      if (w_mult_done) r_fee_slot <= r_slot;
    end
  end

  fee_serial_mult #(
    .TIME_W (TIME_W),
    .RATE_W (RATE_W),
    .RATE   (RATE)
  ) u_fee_mult (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_mult_start),
    .i_multiplier (w_duration),
    .o_busy       (w_mult_busy),
    .o_done       (w_mult_done),
    .o_product    (w_product)
  );

`ifdef PARKING_REVENUE_EN
  logic [FEE_W+7:0] r_revenue;

  always_ff @(posedge clk) begin
    if (rst) r_revenue <= '0;
    else if (r_state == DONE) r_revenue <= r_revenue + (FEE_W + 8)'(w_product);
  end

  assign revenue = r_revenue;
`endif

  assign entry_ack  = r_entry_ack;
  assign entry_nack = r_entry_nack;
  assign entry_slot = r_entry_slot;
  assign exit_ready = w_exit_ready;
  assign exit_err   = r_exit_err;
  assign fee_valid  = w_fee_valid;
  assign fee        = w_product;
  assign fee_slot   = r_fee_slot;
  assign free_mask  = ~r_occ;
  assign full       = ~w_any_free;
  assign now        = r_now;

endmodule
`default_nettype wire

// File: doc/parking_lot_ctrl.md
# parking_lot_ctrl

Parametrised, clocked parking-lot controller: tracks occupancy of NUM_SLOTS bays, allocates the lowest-indexed free bay on an entry request, time-stamps it from an internal wrapping time counter, and on exit computes the fee as (stay duration × RATE) with a serial shift-add multiplier. It is the sequential successor to the fixed 4-bay combinational allocator and fee datapath, and sits between the gate sensors and the billing display.

## Interface
- NUM_SLOTS, 4: number of bays (2..16).
- TIME_W, 4: width of time counter, entry stamps and duration.
- RATE_W, 4: width of per-unit rate.
- RATE, 2: fee per time unit; constant.
- FEE_W, TIME_W+RATE_W: fee width (derived, not overridable).
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe; advances time counter by one unit.
- entry_req  in  1  vehicle at entry gate (one-cycle pulse).
- entry_ack  out  1  pulse: bay allocated.
- entry_nack  out  1  pulse: lot full, request refused.
- entry_slot  out  NUM_SLOTS  one-hot bay granted; valid with entry_ack.
- exit_req  in  1  vehicle leaving; sampled only when exit_ready.
- exit_slot  in  $clog2(NUM_SLOTS)  index of leaving bay.
- exit_ready  out  1  billing engine idle.
- exit_err  out  1  pulse: exit_slot not occupied or out of range.
- fee_valid  out  1  pulse: fee and fee_slot valid.
- fee  out  FEE_W  charge for completed stay.
- fee_slot  out  $clog2(NUM_SLOTS)  bay that was billed.
- free_mask  out  NUM_SLOTS  bit i = 1 when bay i is free.
- full  out  1  free_mask == 0.
- now  out  TIME_W  current time counter.

## Operation
- Time: now increments on tick, wraps 2^TIME_W-1 -> 0.
- Entry: entry_req at cycle t; if free_mask != 0, at t+1 entry_ack=1, entry_slot = lowest-indexed free bay, bay marked occupied, stamp[bay] = now as sampled at t. If full, entry_nack=1 at t+1, no state change.
- Exit FSM states: IDLE, LOAD, MULT, DONE.
- IDLE: exit_ready=1. exit_req with unoccupied or out-of-range exit_slot -> exit_err pulse next cycle, stay IDLE. Valid -> capture slot and now, go LOAD.
- LOAD: duration = (captured_now - stamp[slot]) mod 2^TIME_W (two's-complement subtract, wrap intended); duration 0 billed as 1 (minimum charge). Go MULT.
- MULT: TIME_W iterations, one duration bit per cycle, LSB first, accumulate RATE shifted left. Go DONE.
- DONE: fee_valid=1 for one cycle, fee_slot=slot, bay freed in the same cycle; return to IDLE.
- fee never overflows: max (2^TIME_W-1)×(2^RATE_W-1) fits FEE_W.
- Entries proceed during billing. A bay freed in DONE is visible in free_mask from the next cycle; an entry_req in the DONE cycle does not get that bay.
- tick in the exit-accept cycle: the pre-increment now is captured.
- exit_req while exit_ready=0: ignored, no error.

## Timing
- Reset values: all bays free (free_mask all ones), full=0, now=0, all stamps 0, FSM IDLE, exit_ready=1, entry_ack/entry_nack/exit_err/fee_valid=0, entry_slot=0, fee=0, fee_slot=0.
- Entry latency: 1 cycle. Exit error latency: 1 cycle.
- Fee latency: fee_valid exactly TIME_W+2 cycles after the accept cycle (6 at defaults); exit_ready low from accept+1 until the cycle after DONE.
- fee/fee_slot hold last value until the next DONE.
- rst mid-billing: aborts, no fee_valid, all bays freed, now=0.

## Configuration
- PARKING_REVENUE_EN defined: adds output revenue (FEE_W+8 bits, reset 0), incremented by fee in each DONE cycle, wrapping on overflow.
- Undefined: no revenue port or accumulator; all other behaviour identical.

## Structure
- Shared package parking_pkg: FSM state enum (IDLE, LOAD, MULT, DONE), default NUM_SLOTS/TIME_W/RATE_W/RATE constants, FEE_W derivation.
- One sub-module: fee_serial_mult (start, multiplicand RATE, TIME_W-bit multiplier, busy/done, FEE_W product), driven by LOAD/MULT.
- Lowest-free-bay priority encoder and stamp array stay in the top level.

## Test plan
- Reset, 4 entry_req pulses at now=0 -> entry_slot 0001, 0010, 0100, 1000; full=1; 5th -> entry_nack, free_mask 0000.
- Bay 1 stamped at now=3, 5 ticks, exit_slot=1 -> fee_valid 6 cycles after accept, fee=10, fee_slot=1, free_mask bit 1 set next cycle.
- Wrap: stamp at now=14, 4 ticks (now=2), exit -> duration 4, fee=8.
- Exit same tick as entry (duration 0) -> fee=2; exit on free bay 2 -> exit_err, FSM stays IDLE.
- entry_req in DONE cycle while otherwise full -> entry_nack; exit_req during MULT ignored; rst during MULT -> no fee_valid, free_mask 1111, now=0.
- With PARKING_REVENUE_EN: fees 10 then 8 -> revenue=18; reset -> 0.
